// File: rtl/bmp_stream_writer.sv
// Frames a stream of filtered pixel bytes into a complete 24-bit uncompressed BMP file.
// The output is a 54-byte header, then bottom-up rows zero-padded to a 4-byte multiple.
module bmp_stream_writer #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
  localparam int ROW_BYTES = 3 * WIDTH;
  localparam int PAD       = (4 - ROW_BYTES % 4) % 4;
  localparam int IMG_SIZE  = HEIGHT * (ROW_BYTES + PAD);
  localparam int FILE_SIZE = 54 + IMG_SIZE;

  localparam logic [31:0] FILE_SIZE_W = 32'(FILE_SIZE);
  localparam logic [31:0] IMG_SIZE_W  = 32'(IMG_SIZE);
  localparam logic [31:0] WIDTH_W     = 32'(WIDTH);
  localparam logic [31:0] HEIGHT_W    = 32'(HEIGHT);
  localparam logic [13:0] COL_LAST    = 14'(ROW_BYTES - 1);
  localparam logic [11:0] ROW_LAST    = 12'(HEIGHT - 1);
  localparam logic [1:0]  PAD_LAST    = 2'((PAD == 0) ? 0 : PAD - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PAD    = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [5:0]  hdr_idx_q, hdr_idx_d;
  logic [13:0] col_cnt_q, col_cnt_d;
  logic [11:0] row_cnt_q, row_cnt_d;
  logic [1:0]  pad_cnt_q, pad_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        slot_free;
  logic        row_done;
  logic [31:0] hdr_word;
  logic [1:0]  hdr_sel;
  logic [7:0]  hdr_byte;
  logic        unused_in_hi;

  assign unused_in_hi = ^in_data[31:8];
  assign slot_free    = !out_valid_q || out_ready;
  assign in_ready     = (state_q == S_DATA) && slot_free;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Every header field starts at an offset that is 2 mod 4, so the byte lane
  // within its 32-bit word is (idx + 2) mod 4; "BM" sits in the upper lanes.
  always_comb begin
    hdr_sel  = hdr_idx_q[1:0] + 2'd2;
    hdr_word = 32'd0;
    if (hdr_idx_q <= 6'd1)                             hdr_word = 32'h4D42_0000;
    else if (hdr_idx_q <= 6'd5)                        hdr_word = FILE_SIZE_W;
    else if (hdr_idx_q >= 6'd10 && hdr_idx_q <= 6'd13) hdr_word = 32'd54;
    else if (hdr_idx_q >= 6'd14 && hdr_idx_q <= 6'd17) hdr_word = 32'd40;
    else if (hdr_idx_q >= 6'd18 && hdr_idx_q <= 6'd21) hdr_word = WIDTH_W;
    else if (hdr_idx_q >= 6'd22 && hdr_idx_q <= 6'd25) hdr_word = HEIGHT_W;
    else if (hdr_idx_q >= 6'd26 && hdr_idx_q <= 6'd29) hdr_word = 32'h0018_0001;
    else if (hdr_idx_q >= 6'd34 && hdr_idx_q <= 6'd37) hdr_word = IMG_SIZE_W;
    else if (hdr_idx_q >= 6'd38 && hdr_idx_q <= 6'd45) hdr_word = 32'd2835;
    hdr_byte = hdr_word[8*hdr_sel +: 8];
  end

  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    pad_cnt_d   = pad_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    row_done    = 1'b0;

    // A free slot drains unless something below loads it this cycle.
    if (slot_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_HEADER;
          busy_d    = 1'b1;
          hdr_idx_d = 6'd0;
        end
      end
      S_HEADER: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = hdr_byte;
          if (hdr_idx_q == 6'd53) begin
            hdr_idx_d = 6'd0;
            state_d   = S_DATA;
          end else begin
            hdr_idx_d = hdr_idx_q + 6'd1;
          end
        end
      end
      S_DATA: begin
        if (in_valid && slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data[7:0];
          if (col_cnt_q == COL_LAST) begin
            col_cnt_d = 14'd0;
            if (PAD > 0) state_d = S_PAD;
            else         row_done = 1'b1;
          end else begin
            col_cnt_d = col_cnt_q + 14'd1;
          end
        end
      end
      S_PAD: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = 8'h00;
          if (pad_cnt_q == PAD_LAST) begin
            pad_cnt_d = 2'd0;
            row_done  = 1'b1;
          end else begin
            pad_cnt_d = pad_cnt_q + 2'd1;
          end
        end
      end
      S_FLUSH: begin
        if (out_valid_q && out_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The byte loaded this cycle closed a row; on the final row it ends the file.
    if (row_done) begin
      if (row_cnt_q == ROW_LAST) begin
        row_cnt_d  = 12'd0;
        out_last_d = 1'b1;
        state_d    = S_FLUSH;
      end else begin
        row_cnt_d = row_cnt_q + 12'd1;
        state_d   = S_DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hdr_idx_q   <= 6'd0;
      col_cnt_q   <= 14'd0;
      row_cnt_q   <= 12'd0;
      pad_cnt_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
endmodule
